// File: rtl/bsg_mux_bitwise_merge_arb.sv
// bsg_mux_bitwise_merge_arb
//
// Two requesters write masked data into one shared width_p-bit shadow
// register. Each register bit has its own mux. The mux selects a granted
// requester's data bit where that requester's mask is set. Otherwise it keeps
// the held bit.
//
// Requesters with disjoint masks are merged in the same cycle. Requesters with
// overlapping masks are served one at a time in round-robin order. Each updated
// register value is offered downstream on a valid/yumi handshake. Accepting a
// new write in the same cycle that downstream consumes the old one costs no
// bubble.
//
// Ports
//   clk_i        clock
//   reset_i      synchronous, active-high reset
//   v_i[1:0]     per-requester valid, index 0 = requester 0
//   data_i       requester k data at [k*width_p +: width_p]
//   mask_i       requester k write mask, same packing; 1 = overwrite bit
//   yumi_o[1:0]  requester k consumed this cycle (combinational grant)
//   v_o          updated register value pending
//   data_o       shadow register value (meaningful when v_o)
//   yumi_i       downstream consumes data_o this cycle (only while v_o)
//   conflicts_o  saturating count of overlapping-mask grants

module bsg_mux_bitwise_merge_arb #(
    parameter int width_p     = 16,
    parameter int ctr_width_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [1:0]             v_i,
    input  logic [2*width_p-1:0]   data_i,
    input  logic [2*width_p-1:0]   mask_i,
    output logic [1:0]             yumi_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   yumi_i,
    output logic [ctr_width_p-1:0] conflicts_o
);

    logic [width_p-1:0]     r_r;
    logic                   v_r;
    logic                   last_r;
    logic [ctr_width_p-1:0] cnt_r;

    logic [width_p-1:0]     data0, data1, mask0, mask1;
    logic                   can_acc;
    logic                   conflict;
    logic                   winner;
    logic [1:0]             grant;
    logic [width_p-1:0]     r_mid;
    logic [width_p-1:0]     r_n;
    logic                   cnt_sat;

    assign data0 = data_i[0*width_p +: width_p];
    assign data1 = data_i[1*width_p +: width_p];
    assign mask0 = mask_i[0*width_p +: width_p];
    assign mask1 = mask_i[1*width_p +: width_p];

    // The output slot is free when it is empty or is being drained right now.
    assign can_acc  = ~v_r | yumi_i;
    assign conflict = v_i[0] & v_i[1] & (|(mask0 & mask1));

    // last_r holds the previous conflict winner, so the other requester wins next.
    assign winner   = ~last_r;
    assign cnt_sat  = &cnt_r;

    always_comb begin
        grant = 2'b00;
        if (!reset_i && can_acc) begin
            if (conflict) begin
                grant = winner ? 2'b10 : 2'b01;
            end else begin
                grant = v_i;
            end
        end
    end

    assign yumi_o = grant;

    // Per-bit merge muxes. Requester 0 is applied first and requester 1 second.
    // The order has an effect only when both are granted, and then the masks
    // are disjoint.
    for (genvar b = 0; b < width_p; b++) begin : g_bit
        assign r_mid[b] = (grant[0] & mask0[b]) ? data0[b] : r_r[b];
        assign r_n[b]   = (grant[1] & mask1[b]) ? data1[b] : r_mid[b];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_r    <= '0;
            v_r    <= 1'b0;
            last_r <= 1'b1;
            cnt_r  <= '0;
        end else if (|grant) begin
            // A zero-mask grant still republishes the unchanged value.
            r_r <= r_n;
            v_r <= 1'b1;
            if (conflict) begin
                last_r <= winner;
                if (!cnt_sat) begin
                    cnt_r <= cnt_r + ctr_width_p'(1);
                end
            end
        end else if (yumi_i) begin
            v_r <= 1'b0;
        end
    end

    assign v_o         = v_r;
    assign data_o      = r_r;
    assign conflicts_o = cnt_r;

    // Handshake protocol checks.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_r));
            assert (!(|(yumi_o & ~v_i)));
        end
    end

endmodule

// File: tb/tb_bsg_mux_bitwise_merge_arb.sv
module tb_bsg_mux_bitwise_merge_arb;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [1:0]    v_i;
    logic [2*W-1:0] data_i, mask_i;
    logic          yumi_i;
    logic [1:0]    yumi_o, yumi_o_s;
    logic          v_o, v_o_s;
    logic [W-1:0]  data_o, data_o_s;
    logic [7:0]    conflicts_o;
    logic [1:0]    conflicts_o_s;

    always #5 clk = ~clk;

    bsg_mux_bitwise_merge_arb #(.width_p(W), .ctr_width_p(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .mask_i(mask_i), .yumi_o(yumi_o), .v_o(v_o), .data_o(data_o),
        .yumi_i(yumi_i), .conflicts_o(conflicts_o));

    bsg_mux_bitwise_merge_arb #(.width_p(W), .ctr_width_p(2)) dut_sat (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .mask_i(mask_i), .yumi_o(yumi_o_s), .v_o(v_o_s), .data_o(data_o_s),
        .yumi_i(yumi_i), .conflicts_o(conflicts_o_s));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [W-1:0] m_r;
    logic         m_v;
    logic         m_last;
    logic [7:0]   m_cnt;
    logic [1:0]   m_cnt2;

    typedef struct packed {
        logic         v;
        logic [W-1:0] data;
        logic [7:0]   cnt;
        logic [1:0]   cnt2;
    } exp_t;

    exp_t sb[$];

    task automatic step(input logic rst, input logic [1:0] v,
                        input logic [W-1:0] d0, input logic [W-1:0] m0,
                        input logic [W-1:0] d1, input logic [W-1:0] m1,
                        input logic y);
        logic [1:0] g;
        logic       acc, conf, yy;
        exp_t       e, o;
        @(negedge clk);
        yy      = y & m_v;
        reset_i = rst;
        v_i     = v;
        data_i  = {d1, d0};
        mask_i  = {m1, m0};
        yumi_i  = yy;
        #1;
        acc  = !m_v || yy;
        conf = v[0] && v[1] && ((m0 & m1) != '0);
        g    = 2'b00;
        if (!rst && acc) begin
            if (!conf) g = v;
            else if (m_last) g = 2'b01;
            else g = 2'b10;
        end
        chk("yumi_o", {30'd0, yumi_o}, {30'd0, g});
        chk("yumi_o_sat", {30'd0, yumi_o_s}, {30'd0, g});
        if (rst) begin
            m_r = '0; m_v = 1'b0; m_last = 1'b1; m_cnt = '0; m_cnt2 = '0;
        end else if (g != 2'b00) begin
            for (int b = 0; b < W; b++) begin
                if (g[0] && m0[b]) m_r[b] = d0[b];
                if (g[1] && m1[b]) m_r[b] = d1[b];
            end
            m_v = 1'b1;
            if (conf) begin
                m_last = g[1];
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
            end
        end else if (yy) begin
            m_v = 1'b0;
        end
        e.v = m_v; e.data = m_r; e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            chk("v_o", {31'd0, v_o}, {31'd0, o.v});
            chk("data_o", {16'd0, data_o}, {16'd0, o.data});
            chk("conflicts_o", {24'd0, conflicts_o}, {24'd0, o.cnt});
            chk("conflicts_o_sat", {30'd0, conflicts_o_s}, {30'd0, o.cnt2});
        end
    endtask

    localparam logic [W-1:0] MASKS [6] = '{16'h0000, 16'h00FF, 16'hFF00,
                                          16'h0F0F, 16'hFFFF, 16'h000F};

    logic [W-1:0] rd0, rd1, rm0, rm1;
    logic [1:0]   rv;
    logic         ry;

    initial begin
        reset_i = 1'b1; v_i = '0; data_i = '0; mask_i = '0; yumi_i = 1'b0;
        m_r = '0; m_v = 1'b0; m_last = 1'b1; m_cnt = '0; m_cnt2 = '0;

        step(1, 2'b00, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0);
        chk("reset_v_o", {31'd0, v_o}, 32'd0);
        chk("reset_data_o", {16'd0, data_o}, 32'd0);
        chk("reset_conflicts", {24'd0, conflicts_o}, 32'd0);

        // Single requester, then held off by a full, unconsumed slot
        step(0, 2'b01, 16'hABCD, 16'hFFFF, 0, 0, 0);
        chk("single_data", {16'd0, data_o}, 32'h0000ABCD);
        chk("single_v", {31'd0, v_o}, 32'd1);
        step(0, 2'b01, 16'hABCD, 16'hFFFF, 0, 0, 0);
        chk("stall_v", {31'd0, v_o}, 32'd1);

        // Disjoint merge from a zero register
        step(1, 2'b00, 0, 0, 0, 0, 0);
        step(0, 2'b11, 16'h1234, 16'h00FF, 16'h5678, 16'hFF00, 1);
        chk("merge_data", {16'd0, data_o}, 32'h00005634);
        chk("merge_conflicts", {24'd0, conflicts_o}, 32'd0);

        // Overlapping masks, alternating service
        step(0, 2'b11, 16'h0001, 16'h000F, 16'h0002, 16'h000F, 1);
        chk("conf1_nibble", {28'd0, data_o[3:0]}, 32'd1);
        step(0, 2'b11, 16'h0001, 16'h000F, 16'h0002, 16'h000F, 1);
        chk("conf2_nibble", {28'd0, data_o[3:0]}, 32'd2);
        chk("conf2_count", {24'd0, conflicts_o}, 32'd2);

        // Back-pressure, then accept and drain in the same cycle
        for (int i = 0; i < 3; i++) step(0, 2'b10, 0, 0, 16'hBEEF, 16'hFFFF, 0);
        chk("bp_data_stable", {16'd0, data_o}, 32'h00005632);
        step(0, 2'b10, 0, 0, 16'hBEEF, 16'hFFFF, 1);
        chk("bp_release_data", {16'd0, data_o}, 32'h0000BEEF);
        chk("bp_release_v", {31'd0, v_o}, 32'd1);

        // Zero-mask grant republishes the unchanged value
        step(0, 2'b00, 0, 0, 0, 0, 1);
        step(0, 2'b01, 16'h1111, 16'h0000, 0, 0, 0);
        chk("zero_mask_v", {31'd0, v_o}, 32'd1);
        chk("zero_mask_data", {16'd0, data_o}, 32'h0000BEEF);

        // Saturation of a 2-bit conflict counter
        step(1, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 2'b11, 16'h00AA, 16'h00FF, 16'h0055, 16'h00F0, 1);
            chk("sat_seq", {30'd0, conflicts_o_s}, (i < 3) ? i + 1 : 3);
        end

        // Reset while a value is pending
        step(0, 2'b01, 16'hFFFF, 16'hFFFF, 0, 0, 1);
        chk("pre_reset_data", {16'd0, data_o}, 32'h0000FFFF);
        step(1, 2'b11, 16'h1234, 16'hFFFF, 16'h4321, 16'hFFFF, 1);
        chk("mid_reset_v", {31'd0, v_o}, 32'd0);
        chk("mid_reset_data", {16'd0, data_o}, 32'd0);
        step(0, 2'b11, 16'h1234, 16'hFFFF, 16'h4321, 16'hFFFF, 0);
        chk("post_reset_winner", {16'd0, data_o}, 32'h00001234);

        // Random traffic, including conflicts, idles and back-pressure
        for (int i = 0; i < 300; i++) begin
            rv  = 2'($urandom_range(0, 3));
            rd0 = 16'($urandom);
            rd1 = 16'($urandom);
            rm0 = MASKS[$urandom_range(0, 5)];
            rm1 = MASKS[$urandom_range(0, 5)];
            ry  = 1'($urandom_range(0, 1));
            step((i % 97) == 50, rv, rd0, rm0, rd1, rm1, ry);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
